// File: rtl/debounce_onepulse_pkg.sv
// Shared defaults, FSM state type and counter helper for the push-button conditioner.
package debounce_onepulse_pkg;

    localparam int DEB_SAMPLES_DEFAULT  = 4;
    localparam int LONG_TICKS_DEFAULT   = 128;
    localparam int REPEAT_TICKS_DEFAULT = 32;

    typedef enum logic [1:0] {
        PB_IDLE  = 2'd0,
        PB_PRESS = 2'd1,
        PB_HOLD  = 2'd2
    } pb_state_t;

    // Terminal value of an 8-bit tick counter that must span 'ticks' ticks.
    function automatic logic [7:0] last_count(input int ticks);
        return 8'(ticks - 1);
    endfunction

endpackage

// File: rtl/debounce_onepulse_sync_edge.sv
// Two-flop synchronizer. In edge mode the output is a one-cycle pulse on a
// synchronized rising edge; in level mode it is the synchronized level.
module sync_edge #(
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic clk_40M,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    // Two-stage metastability filter for an asynchronous input.
    always_ff @(posedge clk_40M or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    generate
        if (EDGE_MODE) begin : g_edge
            logic edge_p2;

            // Previous synchronized level, used to spot the 0->1 transition.
            always_ff @(posedge clk_40M or negedge rst_n) begin
                if (!rst_n) begin
                    edge_p2 <= 1'b0;
                end else begin
                    edge_p2 <= sync_p1;
                end
            end

            assign q = sync_p1 & ~edge_p2;
        end else begin : g_level
            assign q = sync_p1;
        end
    endgenerate

endmodule

// File: rtl/debounce_onepulse.sv
// Push-button conditioner: samples a raw button on each divided debounce tick,
// filters it, and turns the clean level into press/release/long/repeat events.
module debounce_onepulse
    import debounce_onepulse_pkg::*;
#(
    parameter int DEB_SAMPLES  = DEB_SAMPLES_DEFAULT,
    parameter int LONG_TICKS   = LONG_TICKS_DEFAULT,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEFAULT
) (
    input  logic clk_40M,
    input  logic rst_n,
    input  logic clk_debounce,
    input  logic pb_in,
    output logic pb_debounced,
    output logic pb_press,
    output logic pb_release,
    output logic pb_long,
    output logic pb_repeat
);

    localparam logic [7:0] LONG_LAST   = last_count(LONG_TICKS);
    localparam logic [7:0] REPEAT_LAST = last_count(REPEAT_TICKS);

    logic                   tick;
    logic                   pb_s;
    logic [DEB_SAMPLES-1:0] samp_p0;
    logic                   deb_d;
    logic                   deb_rise;
    logic                   deb_fall;

    pb_state_t  state, state_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [7:0] rep_cnt, rep_cnt_nxt;
    logic       press_nxt, release_nxt, repeat_nxt;

    // The divided clock is only ever sampled as data; its rising edge becomes tick.
    sync_edge #(.EDGE_MODE(1'b1)) u_tick_sync (
        .clk_40M (clk_40M),
        .rst_n   (rst_n),
        .d       (clk_debounce),
        .q       (tick)
    );

    sync_edge #(.EDGE_MODE(1'b0)) u_pb_sync (
        .clk_40M (clk_40M),
        .rst_n   (rst_n),
        .d       (pb_in),
        .q       (pb_s)
    );

    // Sample history; the level only moves once every stored sample agrees.
    always_ff @(posedge clk_40M or negedge rst_n) begin
        if (!rst_n) begin
            samp_p0      <= '0;
            pb_debounced <= 1'b0;
            deb_d        <= 1'b0;
        end else begin
            if (tick) begin
                samp_p0 <= {samp_p0[DEB_SAMPLES-2:0], pb_s};
            end
            if (&samp_p0) begin
                pb_debounced <= 1'b1;
            end else if (~|samp_p0) begin
                pb_debounced <= 1'b0;
            end
            deb_d <= pb_debounced;
        end
    end

    assign deb_rise = pb_debounced & ~deb_d;
    assign deb_fall = ~pb_debounced & deb_d;

    // State, counters and registered strobes.
    always_ff @(posedge clk_40M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PB_IDLE;
            hold_cnt   <= 8'd0;
            rep_cnt    <= 8'd0;
            pb_press   <= 1'b0;
            pb_release <= 1'b0;
            pb_repeat  <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            rep_cnt    <= rep_cnt_nxt;
            pb_press   <= press_nxt;
            pb_release <= release_nxt;
            pb_repeat  <= repeat_nxt;
        end
    end

    // Next state; a debounced fall takes priority over any count reaching its limit.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        rep_cnt_nxt  = rep_cnt;
        press_nxt    = 1'b0;
        release_nxt  = 1'b0;
        repeat_nxt   = 1'b0;
        case (state)
            PB_IDLE: begin
                if (deb_rise) begin
                    state_nxt    = PB_PRESS;
                    press_nxt    = 1'b1;
                    hold_cnt_nxt = 8'd0;
                end
            end
            PB_PRESS: begin
                if (deb_fall) begin
                    state_nxt   = PB_IDLE;
                    release_nxt = 1'b1;
                end else if (tick) begin
                    if (hold_cnt == LONG_LAST) begin
                        state_nxt   = PB_HOLD;
                        repeat_nxt  = 1'b1;
                        rep_cnt_nxt = 8'd0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + 8'd1;
                    end
                end
            end
            PB_HOLD: begin
                if (deb_fall) begin
                    state_nxt   = PB_IDLE;
                    release_nxt = 1'b1;
                end else if (tick) begin
                    if (rep_cnt == REPEAT_LAST) begin
                        repeat_nxt  = 1'b1;
                        rep_cnt_nxt = 8'd0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = PB_IDLE;
            end
        endcase
    end

    assign pb_long = (state == PB_HOLD);

endmodule
